id_ex_operand_stage: RTL and testbench

- Pipeline register between decode/register-file read and the ALU stage of the 5-stage CPU.
- Latches the register-file read data plus decoded control into the EX stage.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls upstream for one cycle and inserts a bubble.
- Honours downstream hold and branch flush.

---
 rtl/id_ex_operand_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand resolution, hazard stall and bubble insertion.
// `define OPFETCH_FWD_EN selects EX/MEM and MEM/WB forwarding; otherwise sources interlock until written back.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] rs_addr_i,
    input  logic [AW-1:0] rt_addr_i,
    input  logic          rs_used_i,
    input  logic          rt_used_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          regwrite_i,
    input  logic          memread_i,
    input  logic [DW-1:0] imm_i,
    input  logic [CW-1:0] ctrl_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic [AW-1:0] exmem_rd_i,
    input  logic          exmem_we_i,
    input  logic [DW-1:0] exmem_data_i,
    input  logic [AW-1:0] memwb_rd_i,
    input  logic          memwb_we_i,
    input  logic [DW-1:0] memwb_data_i,
    input  logic          hold_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic          valid_o,
    output logic [DW-1:0] rs_o,
    output logic [DW-1:0] rt_o,
    output logic [DW-1:0] imm_o,
    output logic [AW-1:0] rd_o,
    output logic          regwrite_o,
    output logic          memread_o,
    output logic [CW-1:0] ctrl_o
);

    logic          r_valid;
    logic [DW-1:0] r_rs;
    logic [DW-1:0] r_rt;
    logic [DW-1:0] r_imm;
    logic [AW-1:0] r_rd;
    logic          r_regwrite;
    logic          r_memread;
    logic [CW-1:0] r_ctrl;

    logic [DW-1:0] w_rs_op;
    logic [DW-1:0] w_rt_op;
    logic          w_hazard;

`ifdef OPFETCH_FWD_EN
    // r0 is hardwired, so a pending write to it must never shadow the register file.
    function automatic logic [DW-1:0] f_fwd(
        input logic [AW-1:0] a,
        input logic [DW-1:0] rf,
        input logic          ex_we,
        input logic [AW-1:0] ex_rd,
        input logic [DW-1:0] ex_d,
        input logic          wb_we,
        input logic [AW-1:0] wb_rd,
        input logic [DW-1:0] wb_d
    );
        if (a == '0)                   return rf;
        else if (ex_we && ex_rd == a)  return ex_d;
        else if (wb_we && wb_rd == a)  return wb_d;
        else                           return rf;
    endfunction

    logic w_rs_ld;
    logic w_rt_ld;

    assign w_rs_op = f_fwd(rs_addr_i, rs_data_i, exmem_we_i, exmem_rd_i, exmem_data_i,
                           memwb_we_i, memwb_rd_i, memwb_data_i);
    assign w_rt_op = f_fwd(rt_addr_i, rt_data_i, exmem_we_i, exmem_rd_i, exmem_data_i,
                           memwb_we_i, memwb_rd_i, memwb_data_i);

    // Only a load in EX is too late to forward; everything else resolves through the muxes.
    assign w_rs_ld  = rs_used_i && (rs_addr_i == r_rd);
    assign w_rt_ld  = rt_used_i && (rt_addr_i == r_rd);
    assign w_hazard = r_valid && r_memread && (r_rd != '0) && id_valid_i && (w_rs_ld || w_rt_ld);
`else
    function automatic logic f_hit(
        input logic [AW-1:0] a,
        input logic          used,
        input logic          ex_busy,
        input logic [AW-1:0] ex_rd,
        input logic          mem_we,
        input logic [AW-1:0] mem_rd,
        input logic          wb_we,
        input logic [AW-1:0] wb_rd
    );
        return used && (a != '0) &&
               ((ex_busy && ex_rd == a) || (mem_we && mem_rd == a) || (wb_we && wb_rd == a));
    endfunction

    logic w_ex_busy;
    logic w_unused_data;

    assign w_rs_op       = rs_data_i;
    assign w_rt_op       = rt_data_i;
    assign w_ex_busy     = r_valid && r_regwrite;
    assign w_unused_data = ^{exmem_data_i, memwb_data_i};

    // Hold the consumer in ID until every in-flight producer has reached the register file.
    assign w_hazard = id_valid_i &&
        (f_hit(rs_addr_i, rs_used_i, w_ex_busy, r_rd, exmem_we_i, exmem_rd_i, memwb_we_i, memwb_rd_i) ||
         f_hit(rt_addr_i, rt_used_i, w_ex_busy, r_rd, exmem_we_i, exmem_rd_i, memwb_we_i, memwb_rd_i));
`endif

    assign stall_o = (w_hazard && !rst_i) || hold_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_ctrl     <= '0;
        end else if (flush_i || (!hold_i && w_hazard)) begin
            // Flush outranks hold; a bubble only needs the qualifying bits cleared.
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (!hold_i) begin
            r_valid    <= id_valid_i;
            r_rs       <= w_rs_op;
            r_rt       <= w_rt_op;
            r_imm      <= imm_i;
            r_rd       <= rd_addr_i;
            r_regwrite <= regwrite_i && id_valid_i;
            r_memread  <= memread_i && id_valid_i;
            r_ctrl     <= ctrl_i;
        end
    end

    assign valid_o    = r_valid;
    assign rs_o       = r_rs;
    assign rt_o       = r_rt;
    assign imm_o      = r_imm;
    assign rd_o       = r_rd;
    assign regwrite_o = r_regwrite;
    assign memread_o  = r_memread;
    assign ctrl_o     = r_ctrl;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: expectations queued at issue, checked by an output monitor.
// Exercises the forwarding build when OPFETCH_FWD_EN is defined, the interlock build otherwise.
module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          id_valid_i;
    logic [AW-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
    logic          rs_used_i, rt_used_i, regwrite_i, memread_i;
    logic [DW-1:0] imm_i, rs_data_i, rt_data_i;
    logic [CW-1:0] ctrl_i;
    logic [AW-1:0] exmem_rd_i, memwb_rd_i;
    logic          exmem_we_i, memwb_we_i;
    logic [DW-1:0] exmem_data_i, memwb_data_i;
    logic          hold_i, flush_i;
    logic          stall_o, valid_o, regwrite_o, memread_o;
    logic [DW-1:0] rs_o, rt_o, imm_o;
    logic [AW-1:0] rd_o;
    logic [CW-1:0] ctrl_o;

    typedef struct packed {
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        logic [DW-1:0] imm;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
        logic [CW-1:0] ctrl;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rs_used_i(rs_used_i), .rt_used_i(rt_used_i),
        .rd_addr_i(rd_addr_i), .regwrite_i(regwrite_i), .memread_i(memread_i),
        .imm_i(imm_i), .ctrl_i(ctrl_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .exmem_rd_i(exmem_rd_i), .exmem_we_i(exmem_we_i), .exmem_data_i(exmem_data_i),
        .memwb_rd_i(memwb_rd_i), .memwb_we_i(memwb_we_i), .memwb_data_i(memwb_data_i),
        .hold_i(hold_i), .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o),
        .rs_o(rs_o), .rt_o(rt_o), .imm_o(imm_o), .rd_o(rd_o),
        .regwrite_o(regwrite_o), .memread_o(memread_o), .ctrl_o(ctrl_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    task automatic drive_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                            input logic rsu, input logic rtu, input logic [AW-1:0] rd,
                            input logic rw, input logic mr, input logic [DW-1:0] imm,
                            input logic [CW-1:0] ctrl, input logic [DW-1:0] rsd,
                            input logic [DW-1:0] rtd);
        id_valid_i = v;   rs_addr_i = rs;  rt_addr_i = rt;  rs_used_i = rsu; rt_used_i = rtu;
        rd_addr_i  = rd;  regwrite_i = rw; memread_i = mr;  imm_i = imm;     ctrl_i = ctrl;
        rs_data_i  = rsd; rt_data_i = rtd;
    endtask

    task automatic drive_pipe(input logic exwe, input logic [AW-1:0] exrd, input logic [DW-1:0] exd,
                              input logic wbwe, input logic [AW-1:0] wbrd, input logic [DW-1:0] wbd);
        exmem_we_i = exwe; exmem_rd_i = exrd; exmem_data_i = exd;
        memwb_we_i = wbwe; memwb_rd_i = wbrd; memwb_data_i = wbd;
    endtask

    task automatic push_exp(input logic [DW-1:0] rs, input logic [DW-1:0] rt, input logic [DW-1:0] imm,
                            input logic [AW-1:0] rd, input logic rw, input logic mr,
                            input logic [CW-1:0] ctrl);
        exp_t e;
        e.rs = rs; e.rt = rt; e.imm = imm; e.rd = rd; e.rw = rw; e.mr = mr; e.ctrl = ctrl;
        exp_q.push_back(e);
    endtask

    // Check the combinational stall just before the edge, then let the edge happen.
    task automatic step(input logic exp_stall, input string nm);
        #1 chk({nm, ".stall"}, 64'(stall_o), 64'(exp_stall));
        @(posedge clk_i);
        #2;
    endtask

    // A new EX entry appears whenever the edge was not held and valid_o is set afterwards.
    always @(posedge clk_i) begin
        logic h;
        exp_t e;
        h = hold_i;
        #1;
        if (!h && valid_o && !rst_i) begin
            if (exp_q.size() == 0) begin
                chk("mon.unexpected_valid", 64'(valid_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("mon.rs", 64'(rs_o), 64'(e.rs));
                chk("mon.rt", 64'(rt_o), 64'(e.rt));
                chk("mon.imm", 64'(imm_o), 64'(e.imm));
                chk("mon.rd", 64'(rd_o), 64'(e.rd));
                chk("mon.regwrite", 64'(regwrite_o), 64'(e.rw));
                chk("mon.memread", 64'(memread_o), 64'(e.mr));
                chk("mon.ctrl", 64'(ctrl_o), 64'(e.ctrl));
            end
        end
    end

    initial begin
        rst_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_pipe(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_i);
        chk("reset.valid", 64'(valid_o), 0);
        chk("reset.rs", 64'(rs_o), 0);
        chk("reset.rd", 64'(rd_o), 0);
        chk("reset.ctrl", 64'(ctrl_o), 0);
        chk("reset.stall", 64'(stall_o), 0);
        rst_i = 1'b0;

`ifdef OPFETCH_FWD_EN
        // EX/MEM beats MEM/WB for rs; rt has no match. Issued as a load to r4.
        @(negedge clk_i);
        drive_id(1, 3, 9, 1, 1, 4, 1, 1, 32'h100, 16'hA001, 32'd3, 32'd9);
        drive_pipe(1, 3, 32'h55, 1, 3, 32'h66);
        push_exp(32'h55, 32'd9, 32'h100, 4, 1, 1, 16'hA001);
        step(0, "fwd_exmem");

        // Load-use on r4: one stall cycle, then a bubble.
        @(negedge clk_i);
        drive_id(1, 4, 9, 1, 1, 6, 1, 0, 32'h200, 16'hA002, 32'h44, 32'd9);
        drive_pipe(0, 0, 0, 1, 9, 32'hABCD);
        step(1, "loaduse");
        chk("loaduse.bubble_valid", 64'(valid_o), 0);
        chk("loaduse.bubble_memread", 64'(memread_o), 0);

        // Retry resolves from MEM/WB without another stall.
        @(negedge clk_i);
        drive_pipe(0, 0, 0, 1, 4, 32'h10);
        push_exp(32'h10, 32'd9, 32'h200, 6, 1, 0, 16'hA002);
        step(0, "loaduse_retry");

        // r0 never forwarded; rt picks up MEM/WB.
        @(negedge clk_i);
        drive_id(1, 0, 9, 1, 1, 8, 0, 0, 32'd7, 16'h0003, 32'd0, 32'd9);
        drive_pipe(1, 0, 32'd7, 1, 9, 32'hABCD);
        push_exp(32'd0, 32'hABCD, 32'd7, 8, 0, 0, 16'h0003);
        step(0, "r0_guard");

        // Address match without write enable must not forward.
        @(negedge clk_i);
        drive_id(1, 2, 9, 1, 1, 10, 1, 0, 32'd1, 16'h0004, 32'h22, 32'h33);
        drive_pipe(0, 2, 32'h99, 0, 9, 32'h77);
        push_exp(32'h22, 32'h33, 32'd1, 10, 1, 0, 16'h0004);
        step(0, "no_we");
`else
        @(negedge clk_i);
        drive_id(1, 1, 2, 1, 1, 5, 1, 0, 32'h1234, 16'hBEEF, 32'h11, 32'h22);
        push_exp(32'h11, 32'h22, 32'h1234, 5, 1, 0, 16'hBEEF);
        step(0, "plain");

        // Consumer of r5 waits while the producer walks EX -> MEM -> WB.
        @(negedge clk_i);
        drive_id(1, 5, 6, 1, 1, 7, 1, 0, 32'h2, 16'h0002, 32'h50, 32'h60);
        step(1, "il_ex");
        chk("il_ex.bubble_valid", 64'(valid_o), 0);
        chk("il_ex.bubble_regwrite", 64'(regwrite_o), 0);
        @(negedge clk_i);
        drive_pipe(1, 5, 32'hDEAD, 0, 0, 0);
        step(1, "il_mem");
        @(negedge clk_i);
        drive_pipe(0, 0, 0, 1, 5, 32'hDEAD);
        step(1, "il_wb");
        @(negedge clk_i);
        drive_pipe(0, 0, 0, 0, 0, 0);
        push_exp(32'h50, 32'h60, 32'h2, 7, 1, 0, 16'h0002);
        step(0, "il_clear");

        // r0 and unused sources never interlock.
        @(negedge clk_i);
        drive_id(1, 0, 7, 1, 0, 8, 0, 1, 32'hFFFF_FFFF, 16'h0001, 32'd0, 32'h77);
        drive_pipe(1, 0, 32'd7, 1, 7, 32'h1);
        push_exp(32'd0, 32'h77, 32'hFFFF_FFFF, 8, 0, 1, 16'h0001);
        step(0, "r0_unused");
`endif

        // Empty slot: control flags gated off.
        @(negedge clk_i);
        drive_id(0, 8, 8, 1, 1, 9, 1, 1, 32'h3, 16'h0005, 32'h1, 32'h2);
        drive_pipe(0, 0, 0, 0, 0, 0);
        step(0, "bubble_in");
        chk("bubble_in.valid", 64'(valid_o), 0);
        chk("bubble_in.regwrite", 64'(regwrite_o), 0);
        chk("bubble_in.memread", 64'(memread_o), 0);

        @(negedge clk_i);
        drive_id(1, 10, 11, 1, 1, 12, 1, 0, 32'd5, 16'h1234, 32'hA, 32'hB);
        push_exp(32'hA, 32'hB, 32'd5, 12, 1, 0, 16'h1234);
        step(0, "pre_hold");

        // Three held cycles with different decode inputs: EX frozen.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            hold_i = 1'b1;
            drive_id(1, 13, 14, 1, 1, 15, 1, 1, 32'd9, 16'h4321, 32'hC, 32'hD);
            step(1, "hold");
            chk("hold.valid", 64'(valid_o), 1);
            chk("hold.rs", 64'(rs_o), 32'hA);
            chk("hold.rd", 64'(rd_o), 12);
        end

        @(negedge clk_i);
        flush_i = 1'b1;
        step(1, "flush_hold");
        chk("flush_hold.valid", 64'(valid_o), 0);
        chk("flush_hold.regwrite", 64'(regwrite_o), 0);
        @(negedge clk_i);
        flush_i = 1'b0; hold_i = 1'b0;
        drive_id(1, 1, 2, 1, 1, 3, 1, 0, 32'd6, 16'h0707, 32'h71, 32'h72);
        push_exp(32'h71, 32'h72, 32'd6, 3, 1, 0, 16'h0707);
        step(0, "pre_reset");

        // Asynchronous reset mid-cycle.
        @(negedge clk_i);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        chk("areset.valid", 64'(valid_o), 0);
        chk("areset.rs", 64'(rs_o), 0);
        chk("areset.rt", 64'(rt_o), 0);
        chk("areset.regwrite", 64'(regwrite_o), 0);
        chk("areset.stall", 64'(stall_o), 0);
        hold_i = 1'b1;
        #1 chk("areset.stall_hold", 64'(stall_o), 1);
        @(negedge clk_i);
        rst_i = 1'b0; hold_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("scoreboard.drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
